regfile_sequencer: RTL and testbench

Command-level controller for the 16-entry register file. Accepts one register operation at a time over a valid/ready handshake and drives the register file's ADDR_A, ADDR_B, DIN and REGX inputs cycle by cycle. Executes multi-cycle MOV, XCHG and RD operations using internal holding registers. Sits between the instruction decoder and the register file; r15 is the PC.

---
 rtl/regfile_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Command-level controller for a 16-entry register file (r15 is the PC).
//   Takes one register operation at a time over a valid/ready handshake and
//   drives the register file's address, load-data and REGX control lines
//   cycle by cycle. MOV, XCHG and RD are multi-cycle and use the holding
//   registers T0/T1.
//
//   Ports
//     CLK, RESET            clock (rising edge), asynchronous active-high reset
//     CMD_VALID/CMD_READY   command handshake
//     CMD_OP                000 NOP, 001 LD, 010 INC, 011 DEC, 100 MOV,
//                           101 XCHG, 110 RD, 111 reserved
//     CMD_RA, CMD_RB        first/destination and second/source register
//     CMD_DATA              immediate for LD
//     RF_DOUT_B             register file B-port read data (comb. from RF_ADDR_B)
//     RF_DIN, RF_ADDR_A,
//     RF_ADDR_B, RF_REGX    register file controls (REGX idle=001, load=000,
//                           inc=111, dec=011)
//     RESULT                RD result, valid with DONE for an RD
//     DONE, ERR             end-of-command pulse, rejection pulse
//
//   Build option
//     PC_GUARD_EN  when defined, LD/MOV/XCHG writing r15 and INC/DEC of r15
//                  are rejected (ERR with DONE one cycle after acceptance).
module regfile_sequencer #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [2:0]    CMD_OP,
  input  logic [AW-1:0] CMD_RA,
  input  logic [AW-1:0] CMD_RB,
  input  logic [DW-1:0] CMD_DATA,
  input  logic [DW-1:0] RF_DOUT_B,
  output logic [DW-1:0] RF_DIN,
  output logic [AW-1:0] RF_ADDR_A,
  output logic [AW-1:0] RF_ADDR_B,
  output logic [2:0]    RF_REGX,
  output logic [DW-1:0] RESULT,
  output logic          DONE,
  output logic          ERR
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_XCHG = 3'b101;
  localparam logic [2:0] OP_RD   = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [2:0] REGX_IDLE = 3'b001;
  localparam logic [2:0] REGX_LOAD = 3'b000;
  localparam logic [2:0] REGX_INC  = 3'b111;
  localparam logic [2:0] REGX_DEC  = 3'b011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    RD_CAP = 3'd2,
    MOV_WR = 3'd3,
    XCH_RB = 3'd4,
    XCH_WA = 3'd5,
    XCH_WB = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] rb_q, rb_d;
  logic [DW-1:0] t0_q, t0_d;
  logic [DW-1:0] t1_q, t1_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] din_q, din_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [2:0]    regx_q, regx_d;
  logic [DW-1:0] result_q, result_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          reject_s;
  logic [2:0]    eff_op_s;

`ifdef PC_GUARD_EN
  localparam logic [AW-1:0] PC_IDX = {AW{1'b1}};

  // True when the command would modify the PC register.
  function automatic logic pc_write_f(input logic [2:0] op,
                                      input logic [AW-1:0] ra,
                                      input logic [AW-1:0] rb);
    logic hit;
    case (op)
      OP_LD, OP_MOV:   hit = (ra == PC_IDX);
      OP_XCHG:         hit = (ra == PC_IDX) || (rb == PC_IDX);
      OP_INC, OP_DEC:  hit = (rb == PC_IDX);
      default:         hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign reject_s = pc_write_f(CMD_OP, CMD_RA, CMD_RB);
`else
  assign reject_s = 1'b0;
`endif

  // A rejected command is executed as the reserved op: no RF activity, ERR.
  assign eff_op_s = reject_s ? OP_RSV : CMD_OP;

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    ready_d  = 1'b0;
    din_d    = '0;
    addr_a_d = '0;
    addr_b_d = '0;
    regx_d   = REGX_IDLE;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          op_d    = eff_op_s;
          ra_d    = CMD_RA;
          rb_d    = CMD_RB;
          state_d = EXEC;
          case (eff_op_s)
            OP_NOP: done_d = 1'b1;
            OP_LD: begin
              addr_a_d = CMD_RA;
              din_d    = CMD_DATA;
              regx_d   = REGX_LOAD;
              done_d   = 1'b1;
            end
            OP_INC: begin
              addr_b_d = CMD_RB;
              regx_d   = REGX_INC;
              done_d   = 1'b1;
            end
            OP_DEC: begin
              addr_b_d = CMD_RB;
              regx_d   = REGX_DEC;
              done_d   = 1'b1;
            end
            OP_MOV, OP_RD: addr_b_d = CMD_RB;
            OP_XCHG:       addr_b_d = CMD_RA;
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end else begin
          ready_d = 1'b1;
        end
      end

      EXEC: begin
        case (op_q)
          OP_RD: begin
            result_d = RF_DOUT_B;
            done_d   = 1'b1;
            state_d  = RD_CAP;
          end
          OP_MOV: begin
            // RF_DIN in MOV_WR equals T0, which is being captured now.
            t0_d     = RF_DOUT_B;
            addr_a_d = ra_q;
            din_d    = RF_DOUT_B;
            regx_d   = REGX_LOAD;
            done_d   = 1'b1;
            state_d  = MOV_WR;
          end
          OP_XCHG: begin
            t0_d     = RF_DOUT_B;
            addr_b_d = rb_q;
            state_d  = XCH_RB;
          end
          default: begin
            // Single-cycle commands finished in this cycle.
            ready_d = 1'b1;
            state_d = IDLE;
          end
        endcase
      end

      XCH_RB: begin
        t1_d     = RF_DOUT_B;
        addr_a_d = ra_q;
        din_d    = RF_DOUT_B;
        regx_d   = REGX_LOAD;
        state_d  = XCH_WA;
      end

      XCH_WA: begin
        addr_a_d = rb_q;
        din_d    = t0_q;
        regx_d   = REGX_LOAD;
        done_d   = 1'b1;
        state_d  = XCH_WB;
      end

      RD_CAP, MOV_WR, XCH_WB: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, holding registers and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      op_q     <= OP_NOP;
      ra_q     <= '0;
      rb_q     <= '0;
      t0_q     <= '0;
      t1_q     <= '0;
      ready_q  <= 1'b1;
      din_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      regx_q   <= REGX_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
      ready_q  <= ready_d;
      din_q    <= din_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      regx_q   <= regx_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign CMD_READY = ready_q;
  assign RF_DIN    = din_q;
  assign RF_ADDR_A = addr_a_q;
  assign RF_ADDR_B = addr_b_q;
  assign RF_REGX   = regx_q;
  assign RESULT    = result_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer: contains a behavioural register file
// (r15 increments every cycle) and a scoreboard of expected command
// completions checked whenever DONE is seen.
module tb_regfile_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [2:0]  CMD_OP = 3'b000;
  logic [3:0]  CMD_RA = 4'h0;
  logic [3:0]  CMD_RB = 4'h0;
  logic [15:0] CMD_DATA = 16'h0;
  logic [15:0] RF_DOUT_B;
  logic [15:0] RF_DIN;
  logic [3:0]  RF_ADDR_A;
  logic [3:0]  RF_ADDR_B;
  logic [2:0]  RF_REGX;
  logic [15:0] RESULT;
  logic        DONE;
  logic        ERR;

  regfile_sequencer #(.DW(16), .AW(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_RA(CMD_RA), .CMD_RB(CMD_RB), .CMD_DATA(CMD_DATA),
    .RF_DOUT_B(RF_DOUT_B), .RF_DIN(RF_DIN), .RF_ADDR_A(RF_ADDR_A),
    .RF_ADDR_B(RF_ADDR_B), .RF_REGX(RF_REGX), .RESULT(RESULT),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural register file; not reset so register contents survive RESET.
  logic [15:0] rf [16] = '{default: 16'h0};
  assign RF_DOUT_B = rf[RF_ADDR_B];
  always @(posedge CLK) begin
    if (RF_REGX == 3'b000) rf[RF_ADDR_A] <= RF_DIN;
    else if (RF_REGX == 3'b111) rf[RF_ADDR_B] <= rf[RF_ADDR_B] + 16'd1;
    else if (RF_REGX == 3'b011) rf[RF_ADDR_B] <= rf[RF_ADDR_B] - 16'd1;
    if (!(RF_REGX == 3'b000 && RF_ADDR_A == 4'hF)) rf[15] <= rf[15] + 16'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          acc;
    int          lat;
    logic        err;
    logic [2:0]  regx;
    int          loads;
    logic        chk_res;
    logic [15:0] res;
  } exp_t;

  exp_t sb[$];
  int   load_cnt = 0;

  // Scoreboard monitor: compares each DONE against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RF_REGX == 3'b000) load_cnt = load_cnt + 1;
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("%s_lat", e.tag), cyc - e.acc + 1, e.lat);
          chk($sformatf("%s_err", e.tag), {31'd0, ERR}, {31'd0, e.err});
          chk($sformatf("%s_regx", e.tag), {29'd0, RF_REGX}, {29'd0, e.regx});
          chk($sformatf("%s_loads", e.tag), load_cnt, e.loads);
          if (e.chk_res) chk($sformatf("%s_res", e.tag), {16'd0, RESULT}, {16'd0, e.res});
        end
        load_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [15:0] data, input string tag, input int lat,
                       input logic err, input logic [2:0] regx, input int loads,
                       input logic chk_res, input logic [15:0] res, input logic wait_done);
    exp_t e;
    bit ok;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (CMD_READY) begin ok = 1; break; end
      @(negedge CLK);
    end
    if (!ok) begin
      chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    CMD_VALID = 1'b1; CMD_OP = op; CMD_RA = ra; CMD_RB = rb; CMD_DATA = data;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    e.tag = tag; e.acc = cyc; e.lat = lat; e.err = err; e.regx = regx;
    e.loads = loads; e.chk_res = chk_res; e.res = res;
    sb.push_back(e);
    @(negedge CLK);
    chk({tag, "_busy"}, {31'd0, CMD_READY}, 32'd0);
    if (wait_done) begin
      ok = 0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (sb.size() == 0) begin ok = 1; break; end
        @(negedge CLK);
      end
      if (!ok) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      sb.delete();
      @(negedge CLK);
      chk({tag, "_ready_back"}, {31'd0, CMD_READY}, 32'd1);
    end
  endtask

  logic [15:0] pc_a;

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_ready", {31'd0, CMD_READY}, 32'd1);
    chk("rst_regx", {29'd0, RF_REGX}, 32'd1);
    chk("rst_done_err", {30'd0, DONE, ERR}, 32'd0);
    chk("rst_outs", {RF_DIN, RESULT}, 32'd0);
    chk("rst_addr", {24'd0, RF_ADDR_A, RF_ADDR_B}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // LD then RD
    issue(3'b001, 4'd3, 4'd0, 16'h1234, "ld_r3", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b110, 4'd0, 4'd3, 16'h0, "rd_r3", 2, 1'b0, 3'b001, 0, 1'b1, 16'h1234, 1'b1);
    // INC/DEC wrap-around
    issue(3'b001, 4'd4, 4'd0, 16'hFFFF, "ld_r4", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b010, 4'd0, 4'd4, 16'h0, "inc_r4", 1, 1'b0, 3'b111, 0, 1'b0, 16'h0, 1'b1);
    issue(3'b110, 4'd0, 4'd4, 16'h0, "rd_r4a", 2, 1'b0, 3'b001, 0, 1'b1, 16'h0000, 1'b1);
    issue(3'b011, 4'd0, 4'd4, 16'h0, "dec_r4", 1, 1'b0, 3'b011, 0, 1'b0, 16'h0, 1'b1);
    issue(3'b110, 4'd0, 4'd4, 16'h0, "rd_r4b", 2, 1'b0, 3'b001, 0, 1'b1, 16'hFFFF, 1'b1);
    // XCHG
    issue(3'b001, 4'd1, 4'd0, 16'hAAAA, "ld_r1", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b001, 4'd2, 4'd0, 16'h5555, "ld_r2", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b101, 4'd1, 4'd2, 16'h0, "xchg12", 4, 1'b0, 3'b000, 2, 1'b0, 16'h0, 1'b1);
    issue(3'b110, 4'd0, 4'd1, 16'h0, "rd_r1", 2, 1'b0, 3'b001, 0, 1'b1, 16'h5555, 1'b1);
    issue(3'b110, 4'd0, 4'd2, 16'h0, "rd_r2", 2, 1'b0, 3'b001, 0, 1'b1, 16'hAAAA, 1'b1);
    issue(3'b001, 4'd6, 4'd0, 16'h0F0F, "ld_r6", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b101, 4'd6, 4'd6, 16'h0, "xchg66", 4, 1'b0, 3'b000, 2, 1'b0, 16'h0, 1'b1);
    issue(3'b110, 4'd0, 4'd6, 16'h0, "rd_r6", 2, 1'b0, 3'b001, 0, 1'b1, 16'h0F0F, 1'b1);
    // MOV
    issue(3'b001, 4'd1, 4'd0, 16'hBEEF, "ld_r1b", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b100, 4'd7, 4'd1, 16'h0, "mov71", 2, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b110, 4'd0, 4'd7, 16'h0, "rd_r7", 2, 1'b0, 3'b001, 0, 1'b1, 16'hBEEF, 1'b1);
    chk("r7_model", {16'd0, rf[7]}, 32'h0000BEEF);
    // NOP and reserved op
    issue(3'b000, 4'd2, 4'd2, 16'h0, "nop", 1, 1'b0, 3'b001, 0, 1'b0, 16'h0, 1'b1);
    issue(3'b111, 4'd2, 4'd2, 16'h0, "rsv", 1, 1'b1, 3'b001, 0, 1'b0, 16'h0, 1'b1);
    // r15 handling
`ifdef PC_GUARD_EN
    issue(3'b001, 4'hF, 4'd0, 16'h0100, "ld_r15", 1, 1'b1, 3'b001, 0, 1'b0, 16'h0, 1'b1);
    pc_a = rf[15];
    @(negedge CLK);
    chk("pc_inc", {16'd0, rf[15]}, {16'd0, pc_a + 16'd1});
    issue(3'b010, 4'd0, 4'hF, 16'h0, "inc_r15", 1, 1'b1, 3'b001, 0, 1'b0, 16'h0, 1'b1);
    issue(3'b110, 4'd0, 4'hF, 16'h0, "rd_r15", 2, 1'b0, 3'b001, 0, 1'b0, 16'h0, 1'b1);
`else
    issue(3'b001, 4'hF, 4'd0, 16'h0100, "ld_r15", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    chk("r15_loaded", {16'd0, rf[15]}, 32'h00000100);
    pc_a = rf[15];
    @(negedge CLK);
    chk("pc_inc", {16'd0, rf[15]}, {16'd0, pc_a + 16'd1});
`endif

    // RESET in the middle of an XCHG: no loads, no DONE
    issue(3'b001, 4'd3, 4'd0, 16'h3333, "ld_r3b", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b001, 4'd5, 4'd0, 16'h5A5A, "ld_r5", 1, 1'b0, 3'b000, 1, 1'b0, 16'h0, 1'b1);
    issue(3'b101, 4'd3, 4'd5, 16'h0, "xchg_rst", 4, 1'b0, 3'b000, 2, 1'b0, 16'h0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, CMD_READY}, 32'd1);
    chk("mid_rst_regx", {29'd0, RF_REGX}, 32'd1);
    chk("mid_rst_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    repeat (4) @(negedge CLK);
    chk("mid_rst_no_done", {31'd0, DONE}, 32'd0);
    chk("r3_kept", {16'd0, rf[3]}, 32'h00003333);
    chk("r5_kept", {16'd0, rf[5]}, 32'h00005A5A);
    issue(3'b110, 4'd0, 4'd5, 16'h0, "rd_r5", 2, 1'b0, 3'b001, 0, 1'b1, 16'h5A5A, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
